parking_slot_allocator: RTL and testbench

Front-end stage of the parking lot: accepts entry/exit requests carrying a license plate, classifies the vehicle (SUV/sedan), and keeps the slot occupancy table. It chooses or looks up the target floor/slot and issues one move command at a time to the elevator controller downstream over a valid/ready handshake. It drives the parked-plate image and the full/empty flags at the top level.

---
 rtl/parking_pkg.sv | 23 ++
 rtl/parking_slot_allocator_if.sv | 31 +++
 rtl/slot_priority_finder.sv | 21 ++
 rtl/parking_slot_allocator.sv | 168 ++++++++++++++++
 tb/tb_parking_slot_allocator.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking-lot front end.
package parking_pkg;
    localparam int FLOOR_W             = 3;
    localparam int SLOT_W              = 1;
    localparam int DEF_PLATE_W         = 16;
    localparam int DEF_NUM_FLOORS      = 7;
    localparam int DEF_SLOTS_PER_FLOOR = 2;
    localparam int DEF_SUV_FLOORS      = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_REJECT = 2'd3
    } alloc_state_e;

    typedef enum logic [1:0] {
        DONE_OK        = 2'd0,
        DONE_FULL      = 2'd1,
        DONE_NOT_FOUND = 2'd2,
        DONE_INVALID   = 2'd3
    } done_code_e;
endpackage

// File: rtl/parking_slot_allocator_if.sv
// Request / move / done channels between requester, allocator and elevator.
// master = allocator side, slave = environment (requester + elevator).
interface parking_slot_allocator_if #(
    parameter int PLATE_W = parking_pkg::DEF_PLATE_W
);
    import parking_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_op;
    logic [PLATE_W-1:0]   req_plate;
    logic                 move_valid;
    logic                 move_ready;
    logic [FLOOR_W-1:0]   move_floor;
    logic [SLOT_W-1:0]    move_slot;
    logic                 move_dir;
    logic                 done_valid;
    logic [1:0]           done_code;

    modport master (
        input  req_valid, req_op, req_plate, move_ready,
        output req_ready, move_valid, move_floor, move_slot, move_dir,
               done_valid, done_code
    );

    modport slave (
        output req_valid, req_op, req_plate, move_ready,
        input  req_ready, move_valid, move_floor, move_slot, move_dir,
               done_valid, done_code
    );
endinterface

// File: rtl/slot_priority_finder.sv
// Lowest-index first match over a candidate vector.
module slot_priority_finder #(
    parameter  int N     = 14,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_cand,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);
    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_cand[i]) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/parking_slot_allocator.sv
// Parking slot allocator: classifies requests, keeps the occupancy table and
// issues one elevator move at a time. Optional leak guard: PARKING_LEAK_GUARD_EN.
module parking_slot_allocator
    import parking_pkg::*;
#(
    parameter int PLATE_W         = DEF_PLATE_W,
    parameter int NUM_FLOORS      = DEF_NUM_FLOORS,
    parameter int SLOTS_PER_FLOOR = DEF_SLOTS_PER_FLOOR,
    parameter int SUV_FLOORS      = DEF_SUV_FLOORS
) (
    input  logic                                         clock,
    input  logic                                         reset,
    parking_slot_allocator_if.master                     bus,
    input  logic                                         leakage,
    input  logic [FLOOR_W-1:0]                           leakage_floor,
    input  logic                                         leak_clear,
    output logic                                         plate_type,
    output logic [NUM_FLOORS*SLOTS_PER_FLOOR*PLATE_W-1:0] parked,
    output logic                                         empty_suv,
    output logic                                         empty_sedan,
    output logic                                         full_suv,
    output logic                                         full_sedan
);
    localparam int NUM_SLOTS = NUM_FLOORS * SLOTS_PER_FLOOR;
    localparam int IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    alloc_state_e                       r_state, w_next;
    logic                               r_op, r_type, r_done_ok;
    logic [PLATE_W-1:0]                 r_plate;
    logic [IDX_W-1:0]                   r_idx;
    done_code_e                         r_code;
    logic [NUM_SLOTS-1:0][PLATE_W-1:0]  r_slots;

    logic [NUM_FLOORS-1:0]              w_leak;
    logic [NUM_SLOTS-1:0]               w_is_suv, w_used, w_avail, w_free, w_match;
    logic [IDX_W-1:0]                   w_free_idx, w_match_idx, w_lk_idx;
    logic                               w_free_found, w_match_found;
    done_code_e                         w_lk_code;

`ifdef PARKING_LEAK_GUARD_EN
    logic [NUM_FLOORS-1:0] r_leak;

    // Leak marks: clear has priority, out-of-range floors match no entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_leak <= '0;
        end else if (leak_clear) begin
            r_leak <= '0;
        end else if (leakage) begin
            for (int f = 0; f < NUM_FLOORS; f++)
                if (int'(leakage_floor) == f + 1) r_leak[f] <= 1'b1;
        end
    end
    assign w_leak = r_leak;
`else
    logic w_unused_leak;
    assign w_unused_leak = ^{leakage, leakage_floor, leak_clear};
    assign w_leak        = '0;
`endif

    // Per-slot status; slot g lives on floor g/SLOTS_PER_FLOOR (0-based).
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        localparam int FL = g / SLOTS_PER_FLOOR;
        assign w_is_suv[g] = (FL < SUV_FLOORS);
        assign w_used[g]   = |r_slots[g];
        assign w_avail[g]  = !w_used[g] && !w_leak[FL];
        assign w_free[g]   = w_avail[g] && (w_is_suv[g] == r_type);
        assign w_match[g]  = (r_slots[g] == r_plate);
    end

    slot_priority_finder #(.N(NUM_SLOTS)) u_free_find (
        .i_cand (w_free),  .o_idx (w_free_idx),  .o_found (w_free_found)
    );
    slot_priority_finder #(.N(NUM_SLOTS)) u_match_find (
        .i_cand (w_match), .o_idx (w_match_idx), .o_found (w_match_found)
    );

    // Lookup verdict for the held request; plate 0 would match empty slots,
    // so it is rejected before any match is trusted.
    always_comb begin
        w_lk_code = DONE_OK;
        w_lk_idx  = w_match_idx;
        if (r_plate == '0) begin
            w_lk_code = DONE_INVALID;
        end else if (!r_op) begin
            w_lk_idx = w_free_idx;
            if (w_match_found)      w_lk_code = DONE_INVALID;
            else if (!w_free_found) w_lk_code = DONE_FULL;
        end else if (!w_match_found) begin
            w_lk_code = DONE_NOT_FOUND;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (bus.req_valid) w_next = ST_LOOKUP;
            ST_LOOKUP: w_next = (w_lk_code == DONE_OK) ? ST_ISSUE : ST_REJECT;
            ST_ISSUE:  if (bus.move_ready) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Request capture, lookup result and occupancy update on handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_op      <= 1'b0;
            r_type    <= 1'b0;
            r_plate   <= '0;
            r_idx     <= '0;
            r_code    <= DONE_OK;
            r_done_ok <= 1'b0;
            r_slots   <= '0;
        end else begin
            r_done_ok <= 1'b0;
            case (r_state)
                ST_IDLE: if (bus.req_valid) begin
                    r_op    <= bus.req_op;
                    r_plate <= bus.req_plate;
                    r_type  <= bus.req_plate[PLATE_W-1];
                end
                ST_LOOKUP: begin
                    r_idx  <= w_lk_idx;
                    r_code <= w_lk_code;
                end
                ST_ISSUE: if (bus.move_ready) begin
                    r_slots[r_idx] <= r_op ? '0 : r_plate;
                    r_done_ok      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs: move fields are held at 0 outside ISSUE.
    always_comb begin
        bus.req_ready  = (r_state == ST_IDLE);
        bus.move_valid = 1'b0;
        bus.move_floor = '0;
        bus.move_slot  = '0;
        bus.move_dir   = 1'b0;
        bus.done_valid = r_done_ok;
        bus.done_code  = DONE_OK;
        if (r_state == ST_ISSUE) begin
            bus.move_valid = 1'b1;
            bus.move_floor = FLOOR_W'(int'(r_idx) / SLOTS_PER_FLOOR + 1);
            bus.move_slot  = SLOT_W'(int'(r_idx) % SLOTS_PER_FLOOR);
            bus.move_dir   = r_op;
        end else if (r_state == ST_REJECT) begin
            bus.done_valid = 1'b1;
            bus.done_code  = r_code;
        end
    end

    assign plate_type  = r_type;
    assign parked      = r_slots;
    assign empty_suv   = ~|(w_used  &  w_is_suv);
    assign empty_sedan = ~|(w_used  & ~w_is_suv);
    assign full_suv    = ~|(w_avail &  w_is_suv);
    assign full_sedan  = ~|(w_avail & ~w_is_suv);
endmodule

// File: tb/tb_parking_slot_allocator.sv
`define CHK(n, a, e) chk(n, 256'(a), 256'(e))

module tb_parking_slot_allocator;
    import parking_pkg::*;

    localparam int PW = 16, NF = 7, SPF = 2, SUVF = 3, NS = NF * SPF;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic leakage = 1'b0;
    logic [2:0] leakage_floor = 3'd0;
    logic leak_clear = 1'b0;
    logic plate_type;
    logic [NS*PW-1:0] parked;
    logic empty_suv, empty_sedan, full_suv, full_sedan;

    parking_slot_allocator_if #(.PLATE_W(PW)) bus();

    parking_slot_allocator #(
        .PLATE_W(PW), .NUM_FLOORS(NF), .SLOTS_PER_FLOOR(SPF), .SUV_FLOORS(SUVF)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .leakage(leakage), .leakage_floor(leakage_floor), .leak_clear(leak_clear),
        .plate_type(plate_type), .parked(parked),
        .empty_suv(empty_suv), .empty_sedan(empty_sedan),
        .full_suv(full_suv), .full_sedan(full_sedan)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_fail = 0;
    logic [PW-1:0] m_park [1:NF][0:SPF-1];
    bit            m_leak [1:NF];
    logic [2:0]    last_floor;
    logic [2:0]    exp_floor;

    typedef struct {
        bit            op;
        logic [PW-1:0] plate;
        int            code;
        int            fl;
        int            sl;
    } vec_t;
    vec_t tab[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int f = 1; f <= NF; f++) begin
            m_leak[f] = 1'b0;
            for (int s = 0; s < SPF; s++) m_park[f][s] = '0;
        end
    endtask

    task automatic model_lookup(input bit op, input logic [PW-1:0] plate,
                                output int code, output int fl, output int sl);
        int hf, hs;
        hf = 0; hs = 0; code = 3; fl = 0; sl = 0;
        if (plate == '0) return;
        for (int f = 1; f <= NF; f++)
            for (int s = 0; s < SPF; s++)
                if (m_park[f][s] == plate) begin hf = f; hs = s; end
        if (op) begin
            if (hf != 0) begin code = 0; fl = hf; sl = hs; end
            else code = 2;
        end else if (hf != 0) begin
            code = 3;
        end else begin
            code = 1;
            for (int f = 1; f <= NF; f++)
                for (int s = 0; s < SPF; s++)
                    if (code != 0 && ((f <= SUVF) == plate[PW-1]) && !m_leak[f]
                        && m_park[f][s] == '0) begin
                        code = 0; fl = f; sl = s;
                    end
        end
    endtask

    task automatic check_state(input string tag);
        logic [255:0] img;
        bit e_suv, e_sed, f_suv, f_sed;
        img = '0; e_suv = 1; e_sed = 1; f_suv = 1; f_sed = 1;
        for (int f = 1; f <= NF; f++)
            for (int s = 0; s < SPF; s++) begin
                img[((f-1)*SPF+s)*PW +: PW] = m_park[f][s];
                if (m_park[f][s] != '0) begin
                    if (f <= SUVF) e_suv = 0; else e_sed = 0;
                end else if (!m_leak[f]) begin
                    if (f <= SUVF) f_suv = 0; else f_sed = 0;
                end
            end
        `CHK({tag, "_parked"}, parked, img);
        `CHK({tag, "_flags"}, {empty_suv, empty_sedan, full_suv, full_sedan},
             {e_suv, e_sed, f_suv, f_sed});
    endtask

    task automatic check_reset(input string tag);
        `CHK({tag, "_outs"}, {bus.req_ready, bus.move_valid, bus.done_valid, bus.done_code,
             bus.move_floor, bus.move_slot, bus.move_dir, plate_type}, {1'b1, 10'b0});
        `CHK({tag, "_parked"}, parked, 0);
        `CHK({tag, "_flags"}, {empty_suv, empty_sedan, full_suv, full_sedan}, 4'b1100);
    endtask

    task automatic do_req(input bit op, input logic [PW-1:0] plate, input int delay,
                          input bit use_tab, input int t_code, input int t_fl, input int t_sl);
        int code, fl, sl;
        model_lookup(op, plate, code, fl, sl);
        if (use_tab) begin code = t_code; fl = t_fl; sl = t_sl; end
        `CHK("req_ready_idle", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_plate = plate;
        @(negedge clock);
        bus.req_valid = 1'b0;
        `CHK("lookup_busy", {bus.req_ready, bus.move_valid, bus.done_valid}, 3'b000);
        `CHK("plate_type", plate_type, plate[PW-1]);
        @(negedge clock);
        if (code == 0) begin
            last_floor = bus.move_floor;
            `CHK("move_cmd", {bus.move_valid, bus.move_floor, bus.move_slot, bus.move_dir, bus.done_valid},
                 {1'b1, 3'(fl), 1'(sl), op, 1'b0});
            for (int i = 0; i < delay; i++) begin
                @(negedge clock);
                `CHK("move_hold", {bus.move_valid, bus.move_floor, bus.move_slot, bus.move_dir, bus.req_ready},
                     {1'b1, 3'(fl), 1'(sl), op, 1'b0});
            end
            bus.move_ready = 1'b1;
            @(negedge clock);
            bus.move_ready = 1'b0;
            `CHK("done_ok", {bus.done_valid, bus.done_code, bus.move_valid, bus.req_ready},
                 {1'b1, 2'd0, 1'b0, 1'b1});
            m_park[fl][sl] = op ? '0 : plate;
        end else begin
            `CHK("reject", {bus.done_valid, bus.done_code, bus.move_valid}, {1'b1, 2'(code), 1'b0});
            @(negedge clock);
            `CHK("reject_end", {bus.done_valid, bus.req_ready}, 2'b01);
        end
        check_state("after_req");
    endtask

    task automatic leak_pulse(input logic [2:0] fl, input bit lk, input bit clr);
        leakage = lk; leakage_floor = fl; leak_clear = clr;
        @(negedge clock);
        leakage = 1'b0; leak_clear = 1'b0;
`ifdef PARKING_LEAK_GUARD_EN
        if (clr) begin
            for (int f = 1; f <= NF; f++) m_leak[f] = 1'b0;
        end else if (lk && int'(fl) >= 1 && int'(fl) <= NF) begin
            m_leak[int'(fl)] = 1'b1;
        end
`endif
        check_state("leak");
    endtask

    initial begin
        int code, fl, sl, r, k;
        logic [PW-1:0] p;
        bus.req_valid = 1'b0; bus.req_op = 1'b0; bus.req_plate = '0; bus.move_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        check_reset("reset");
        reset = 1'b1;
        @(negedge clock);

        tab.push_back('{1'b0, 16'h8001, 0, 1, 0});
        tab.push_back('{1'b0, 16'h8002, 0, 1, 1});
        tab.push_back('{1'b0, 16'h8003, 0, 2, 0});
        tab.push_back('{1'b0, 16'h8004, 0, 2, 1});
        tab.push_back('{1'b0, 16'h8005, 0, 3, 0});
        tab.push_back('{1'b0, 16'h8006, 0, 3, 1});
        tab.push_back('{1'b0, 16'h8007, 1, 0, 0});
        tab.push_back('{1'b0, 16'h0042, 0, 4, 0});
        tab.push_back('{1'b1, 16'h0042, 0, 4, 0});
        tab.push_back('{1'b1, 16'h1234, 2, 0, 0});
        tab.push_back('{1'b0, 16'h0000, 3, 0, 0});
        tab.push_back('{1'b1, 16'h0000, 3, 0, 0});
        tab.push_back('{1'b0, 16'h8003, 3, 0, 0});
        tab.push_back('{1'b1, 16'h8001, 0, 1, 0});
        tab.push_back('{1'b1, 16'h8003, 0, 2, 0});
        for (int i = 0; i < tab.size(); i++) begin
            do_req(tab[i].op, tab[i].plate, 0, 1'b1, tab[i].code, tab[i].fl, tab[i].sl);
            if (i == 5) begin
                n_chk++;
                if (full_suv !== 1'b1) begin
                    n_fail++;
                    $display("FAIL full_suv_after_six: got %0b", full_suv);
                end
            end
        end

        leak_pulse(3'd1, 1'b1, 1'b0);
        do_req(1'b0, 16'h8102, 1, 1'b0, 0, 0, 0);
`ifdef PARKING_LEAK_GUARD_EN
        exp_floor = 3'd2;
`else
        exp_floor = 3'd1;
`endif
        n_chk++;
        if (last_floor !== exp_floor) begin
            n_fail++;
            $display("FAIL leak_alloc_floor: got %0d expected %0d", last_floor, exp_floor);
        end
        leak_pulse(3'd0, 1'b0, 1'b1);
        do_req(1'b0, 16'h8103, 0, 1'b0, 0, 0, 0);
`ifdef PARKING_LEAK_GUARD_EN
        exp_floor = 3'd1;
`else
        exp_floor = 3'd2;
`endif
        n_chk++;
        if (last_floor !== exp_floor) begin
            n_fail++;
            $display("FAIL clear_alloc_floor: got %0d expected %0d", last_floor, exp_floor);
        end
        leak_pulse(3'd4, 1'b1, 1'b1);
        leak_pulse(3'd0, 1'b1, 1'b0);
        do_req(1'b0, 16'h0077, 0, 1'b0, 0, 0, 0);
        n_chk++;
        if (last_floor !== 3'd4) begin
            n_fail++;
            $display("FAIL floor4_after_clear_wins: got %0d", last_floor);
        end

        model_lookup(1'b1, 16'h8002, code, fl, sl);
        bus.req_valid = 1'b1; bus.req_op = 1'b1; bus.req_plate = 16'h8002;
        @(negedge clock);
        bus.req_valid = 1'b0;
        @(negedge clock);
        `CHK("stall_move", {bus.move_valid, bus.move_floor, bus.move_slot, bus.move_dir},
             {1'b1, 3'(fl), 1'(sl), 1'b1});
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            `CHK("stall_hold", {bus.move_valid, bus.move_floor, bus.move_slot, bus.move_dir,
                 bus.req_ready, bus.done_valid}, {1'b1, 3'(fl), 1'(sl), 1'b1, 2'b00});
        end
        reset = 1'b0;
        #1;
        check_reset("mid_issue_reset");
        @(negedge clock);
        `CHK("no_done_after_reset", bus.done_valid, 1'b0);
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        check_state("post_reset");

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                leak_pulse(3'($urandom_range(0, 7)), 1'b1, ($urandom_range(0, 3) == 0));
            end else if (r == 1) begin
                leak_pulse(3'd0, 1'b0, 1'b1);
            end else begin
                k = $urandom_range(0, 18);
                if (k == 0)      p = '0;
                else if (k <= 8) p = 16'h8000 | 16'(k);
                else             p = 16'(k);
                do_req(($urandom_range(0, 4) < 2), p, $urandom_range(0, 3), 1'b0, 0, 0, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
